// File: rtl/vexecution_unit.sv
// vexecution_unit
//   Vector integer execution unit. A command describes VL elements; the
//   operands arrive as NUM_LANES-wide beats and every accepted beat produces
//   one registered result beat one cycle later. One command is in flight at a
//   time, and a single output register feeds writeback.
//
// Ports
//   clk, reset (asynchronous, active low)
//   cmd_valid/cmd_ready, cmd_op, cmd_vl, cmd_use_scalar, cmd_scalar
//   src_valid/src_ready, src_a, src_b       (lane i at [i*ELEM_WIDTH +: ELEM_WIDTH])
//   res_valid/res_ready, res_data, res_mask, res_last
//   busy                                    (FSM not idle or result pending)
//
// Build option
//   VEXU_SATURATE_EN : when defined, ADD and SUB saturate as signed values;
//                      otherwise they wrap modulo 2^ELEM_WIDTH.

module vexecution_unit #(
  parameter int NUM_LANES  = 4,
  parameter int ELEM_WIDTH = 32,
  parameter int MAX_VL     = 64,
  parameter int VL_WIDTH   = $clog2(MAX_VL) + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [2:0]                      cmd_op,
  input  logic [VL_WIDTH-1:0]             cmd_vl,
  input  logic                            cmd_use_scalar,
  input  logic [ELEM_WIDTH-1:0]           cmd_scalar,
  input  logic                            src_valid,
  output logic                            src_ready,
  input  logic [NUM_LANES*ELEM_WIDTH-1:0] src_a,
  input  logic [NUM_LANES*ELEM_WIDTH-1:0] src_b,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [NUM_LANES*ELEM_WIDTH-1:0] res_data,
  output logic [NUM_LANES-1:0]            res_mask,
  output logic                            res_last,
  output logic                            busy
);

  localparam int SH_W = $clog2(ELEM_WIDTH);
  localparam logic [VL_WIDTH-1:0] LANES_VL = VL_WIDTH'(NUM_LANES);
  localparam logic [VL_WIDTH-1:0] MAX_VL_V = VL_WIDTH'(MAX_VL);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
    OP_XOR = 3'd4, OP_SLL = 3'd5, OP_MIN = 3'd6, OP_MAX = 3'd7
  } op_e;

  typedef enum logic { IDLE, EXEC } state_e;

  state_e                  state;
  op_e                     op_q;
  logic                    use_scalar_q;
  logic [ELEM_WIDTH-1:0]   scalar_q;
  logic [VL_WIDTH-1:0]     remaining;
  logic [VL_WIDTH-1:0]     eff_vl;
  logic                    src_fire;
  logic                    last_beat;
  logic [NUM_LANES*ELEM_WIDTH-1:0] lane_res;
  logic [NUM_LANES-1:0]            lane_mask;

  // Per-lane ALU. MIN/MAX compare signed and return a on equality.
  function automatic logic [ELEM_WIDTH-1:0] alu(input op_e op,
                                                input logic [ELEM_WIDTH-1:0] a,
                                                input logic [ELEM_WIDTH-1:0] b);
    logic [ELEM_WIDTH-1:0] r;
`ifdef VEXU_SATURATE_EN
    logic [ELEM_WIDTH:0] ext;
    ext = '0;
`endif
    r = '0;
    case (op)
`ifdef VEXU_SATURATE_EN
      // One extra sign bit exposes overflow: the top two bits disagree.
      OP_ADD, OP_SUB: begin
        if (op == OP_ADD) ext = {a[ELEM_WIDTH-1], a} + {b[ELEM_WIDTH-1], b};
        else              ext = {a[ELEM_WIDTH-1], a} - {b[ELEM_WIDTH-1], b};
        if (ext[ELEM_WIDTH] != ext[ELEM_WIDTH-1])
          r = ext[ELEM_WIDTH] ? {1'b1, {(ELEM_WIDTH-1){1'b0}}}
                              : {1'b0, {(ELEM_WIDTH-1){1'b1}}};
        else
          r = ext[ELEM_WIDTH-1:0];
      end
`else
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
`endif
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SLL: r = a << b[SH_W-1:0];
      OP_MIN: r = ($signed(b) < $signed(a)) ? b : a;
      OP_MAX: r = ($signed(b) > $signed(a)) ? b : a;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign eff_vl    = (cmd_vl > MAX_VL_V) ? MAX_VL_V : cmd_vl;
  assign cmd_ready = (state == IDLE);
  assign src_ready = (state == EXEC) && (!res_valid || res_ready);
  assign src_fire  = src_valid && src_ready;
  assign last_beat = (remaining <= LANES_VL);
  assign busy      = (state != IDLE) || res_valid;

  // Compute every lane of the current beat; lanes beyond the remaining
  // element count are forced to zero and left out of the mask.
  always_comb begin
    lane_res  = '0;
    lane_mask = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (VL_WIDTH'(i) < remaining) begin
        lane_mask[i] = 1'b1;
        lane_res[i*ELEM_WIDTH +: ELEM_WIDTH] =
          alu(op_q, src_a[i*ELEM_WIDTH +: ELEM_WIDTH],
              use_scalar_q ? scalar_q : src_b[i*ELEM_WIDTH +: ELEM_WIDTH]);
      end
    end
  end

  // Command FSM and the result register. A new beat may overwrite the held
  // result in the same edge it is consumed, giving one beat per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      op_q         <= OP_ADD;
      use_scalar_q <= 1'b0;
      scalar_q     <= '0;
      remaining    <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_mask     <= '0;
      res_last     <= 1'b0;
    end else begin
      if (src_fire) begin
        res_valid <= 1'b1;
        res_data  <= lane_res;
        res_mask  <= lane_mask;
        res_last  <= last_beat;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q         <= op_e'(cmd_op);
            use_scalar_q <= cmd_use_scalar;
            scalar_q     <= cmd_scalar;
            if (eff_vl != '0) begin
              remaining <= eff_vl;
              state     <= EXEC;
            end
          end
        end
        EXEC: begin
          if (src_fire) begin
            if (last_beat) begin
              remaining <= '0;
              state     <= IDLE;
            end else begin
              remaining <= remaining - LANES_VL;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vexecution_unit.sv
// tb_vexecution_unit
//   Directed bench for vexecution_unit with default parameters
//   (4 lanes x 32 bits, MAX_VL 64). Inputs change and outputs are sampled
//   1 time unit after the rising edge. Expected values are hand-computed.

module tb_vexecution_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [6:0]   cmd_vl;
  logic         cmd_use_scalar;
  logic [31:0]  cmd_scalar;
  logic         src_valid;
  logic         src_ready;
  logic [127:0] src_a;
  logic [127:0] src_b;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_data;
  logic [3:0]   res_mask;
  logic         res_last;
  logic         busy;

  int checks = 0;
  int errors = 0;

  vexecution_unit dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_vl(cmd_vl),
    .cmd_use_scalar(cmd_use_scalar), .cmd_scalar(cmd_scalar),
    .src_valid(src_valid), .src_ready(src_ready), .src_a(src_a), .src_b(src_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_mask(res_mask), .res_last(res_last), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                         input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [6:0] vl,
                          input logic use_s, input logic [31:0] scal);
    cmd_valid = 1'b1; cmd_op = op; cmd_vl = vl; cmd_use_scalar = use_s; cmd_scalar = scal;
    tick();
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_vl = 7'd0; cmd_use_scalar = 1'b0; cmd_scalar = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_vl = 7'd0; cmd_use_scalar = 1'b0;
    cmd_scalar = 32'd0; src_valid = 1'b1; src_a = '1; src_b = '1; res_ready = 1'b1;
    tick(); tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid: got %b expected 0", res_valid); end
    checks++; if (res_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_last: got %b expected 0", res_last); end
    checks++; if (res_mask !== 4'h0) begin errors++; $display("[TB] FAIL reset_res_mask: got %h expected 0", res_mask); end
    checks++; if (res_data !== 128'd0) begin errors++; $display("[TB] FAIL reset_res_data: got %h expected 0", res_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b1;
    tick();
    // src_valid is high while idle: it must not be consumed.
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_cmd_ready: got %b expected 1", cmd_ready); end
    checks++; if (src_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_src_ready: got %b expected 0", src_ready); end
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_result: got %b expected 0", res_valid); end
    src_valid = 1'b0; src_a = '0; src_b = '0;
  endtask

  task automatic test_add();
    send_cmd(3'd0, 7'd8, 1'b0, 32'd0);
    src_valid = 1'b1; src_a = pack4(1, 2, 3, 4); src_b = pack4(10, 10, 10, 10);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_no_early_result: got %b expected 0", res_valid); end
    tick();
    checks++; if (res_valid !== 1'b1 || res_data !== pack4(11, 12, 13, 14) || res_mask !== 4'hf || res_last !== 1'b0) begin
      errors++; $display("[TB] FAIL add_beat1: got v=%b d=%h m=%h l=%b expected v=1 d=%h m=f l=0", res_valid, res_data, res_mask, res_last, pack4(11, 12, 13, 14)); end
    src_a = pack4(5, 6, 7, 8);
    tick();
    checks++; if (res_valid !== 1'b1 || res_data !== pack4(15, 16, 17, 18) || res_mask !== 4'hf || res_last !== 1'b1) begin
      errors++; $display("[TB] FAIL add_beat2: got v=%b d=%h m=%h l=%b expected v=1 d=%h m=f l=1", res_valid, res_data, res_mask, res_last, pack4(15, 16, 17, 18)); end
    src_valid = 1'b0;
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL add_idle_pending: got cmd_ready=%b busy=%b expected 1 1", cmd_ready, busy); end
    tick();
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL add_drain: got res_valid=%b busy=%b expected 0 0", res_valid, busy); end
  endtask

  task automatic test_sub_partial();
    send_cmd(3'd1, 7'd5, 1'b0, 32'd0);
    src_valid = 1'b1; src_a = pack4(20, 20, 20, 20); src_b = pack4(5, 5, 5, 5);
    tick();
    checks++; if (res_data !== pack4(15, 15, 15, 15) || res_mask !== 4'hf || res_last !== 1'b0) begin
      errors++; $display("[TB] FAIL sub_beat1: got d=%h m=%h l=%b expected d=%h m=f l=0", res_data, res_mask, res_last, pack4(15, 15, 15, 15)); end
    src_a = pack4(9, 7, 7, 7); src_b = pack4(4, 1, 1, 1);
    tick();
    checks++; if (res_data !== pack4(5, 0, 0, 0) || res_mask !== 4'h1 || res_last !== 1'b1) begin
      errors++; $display("[TB] FAIL sub_beat2: got d=%h m=%h l=%b expected d=%h m=1 l=1", res_data, res_mask, res_last, pack4(5, 0, 0, 0)); end
    src_valid = 1'b0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL sub_back_idle: got cmd_ready=%b expected 1", cmd_ready); end
    tick();
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    send_cmd(3'd0, 7'd8, 1'b0, 32'd0);
    src_valid = 1'b1; src_a = pack4(100, 200, 300, 400); src_b = pack4(1, 2, 3, 4);
    tick();
    src_a = pack4(7, 8, 9, 10); src_b = pack4(1, 1, 1, 1);
    for (int k = 0; k < 3; k++) begin
      checks++; if (res_valid !== 1'b1 || res_data !== pack4(101, 202, 303, 404) || src_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL stall_hold_%0d: got v=%b d=%h src_ready=%b expected v=1 d=%h src_ready=0", k, res_valid, res_data, src_ready, pack4(101, 202, 303, 404)); end
      tick();
    end
    res_ready = 1'b1;
    #1;
    checks++; if (src_ready !== 1'b1 || res_data !== pack4(101, 202, 303, 404)) begin
      errors++; $display("[TB] FAIL stall_release: got src_ready=%b d=%h expected 1 %h", src_ready, res_data, pack4(101, 202, 303, 404)); end
    tick();
    checks++; if (res_valid !== 1'b1 || res_data !== pack4(8, 9, 10, 11) || res_last !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_beat2: got v=%b d=%h l=%b expected v=1 d=%h l=1", res_valid, res_data, res_last, pack4(8, 9, 10, 11)); end
    src_valid = 1'b0;
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_no_duplicate: got %b expected 0", res_valid); end
  endtask

  task automatic test_scalar();
    send_cmd(3'd7, 7'd4, 1'b1, 32'hFFFF_FFFF);
    src_valid = 1'b1; src_a = pack4(32'hFFFF_FFFB, 0, 7, 32'hFFFF_FFFF); src_b = pack4(100, 100, 100, 100);
    tick();
    checks++; if (res_data !== pack4(32'hFFFF_FFFF, 0, 7, 32'hFFFF_FFFF) || res_last !== 1'b1) begin
      errors++; $display("[TB] FAIL max_scalar: got d=%h l=%b expected d=%h l=1", res_data, res_last, pack4(32'hFFFF_FFFF, 0, 7, 32'hFFFF_FFFF)); end
    src_valid = 1'b0;
    send_cmd(3'd4, 7'd4, 1'b1, 32'hFFFF_FFFF);
    src_valid = 1'b1; src_a = {4{32'h0F0F_0F0F}}; src_b = '0;
    tick();
    checks++; if (res_data !== {4{32'hF0F0_F0F0}}) begin
      errors++; $display("[TB] FAIL xor_scalar: got %h expected %h", res_data, {4{32'hF0F0_F0F0}}); end
    src_valid = 1'b0;
  endtask

  task automatic test_misc_ops();
    logic [2:0]  ops [6] = '{3'd2, 3'd3, 3'd5, 3'd6, 3'd7, 3'd1};
    logic [31:0] av  [6] = '{32'hF0F0_F0F0, 32'hF0F0_0000, 32'd1, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd3};
    logic [31:0] bv  [6] = '{32'hFF00_FF00, 32'h0000_0F0F, 32'd33, 32'd3, 32'd3, 32'd5};
    logic [31:0] ev  [6] = '{32'hF000_F000, 32'hF0F0_0F0F, 32'd2, 32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFFE};
    for (int k = 0; k < 6; k++) begin
      send_cmd(ops[k], 7'd4, 1'b0, 32'd0);
      src_valid = 1'b1; src_a = {4{av[k]}}; src_b = {4{bv[k]}};
      tick();
      checks++; if (res_data !== {4{ev[k]}} || res_mask !== 4'hf || res_last !== 1'b1) begin
        errors++; $display("[TB] FAIL op_%0d: got d=%h m=%h l=%b expected d=%h m=f l=1", ops[k], res_data, res_mask, res_last, {4{ev[k]}}); end
      src_valid = 1'b0;
    end
    tick();
  endtask

  task automatic test_vl_bounds();
    send_cmd(3'd0, 7'd0, 1'b0, 32'd0);
    src_valid = 1'b1; src_a = '0; src_b = '0;
    checks++; if (cmd_ready !== 1'b1 || src_ready !== 1'b0) begin errors++; $display("[TB] FAIL vl0_idle: got cmd_ready=%b src_ready=%b expected 1 0", cmd_ready, src_ready); end
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL vl0_no_result: got %b expected 0", res_valid); end
    src_valid = 1'b0;
    // vl=100 clamps to 64: exactly 16 back-to-back beats, last on the 16th.
    send_cmd(3'd0, 7'd100, 1'b0, 32'd0);
    src_valid = 1'b1; src_b = '0;
    for (int k = 0; k < 16; k++) begin
      src_a = pack4(k*4, k*4+1, k*4+2, k*4+3);
      tick();
      checks++; if (res_valid !== 1'b1 || res_data !== pack4(k*4, k*4+1, k*4+2, k*4+3) || res_mask !== 4'hf || res_last !== (k == 15)) begin
        errors++; $display("[TB] FAIL vl100_beat%0d: got v=%b d=%h m=%h l=%b expected v=1 d=%h m=f l=%b", k, res_valid, res_data, res_mask, res_last, pack4(k*4, k*4+1, k*4+2, k*4+3), k == 15); end
    end
    checks++; if (src_ready !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL vl100_end: got src_ready=%b cmd_ready=%b expected 0 1", src_ready, cmd_ready); end
    src_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    send_cmd(3'd0, 7'd64, 1'b0, 32'd0);
    src_valid = 1'b1; src_a = pack4(1, 1, 1, 1); src_b = pack4(1, 1, 1, 1);
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_mid: got res_valid=%b busy=%b cmd_ready=%b expected 0 0 1", res_valid, busy, cmd_ready); end
    src_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1 || src_ready !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_release: got cmd_ready=%b src_ready=%b res_valid=%b expected 1 0 0", cmd_ready, src_ready, res_valid); end
    send_cmd(3'd0, 7'd4, 1'b0, 32'd0);
    src_valid = 1'b1; src_a = pack4(1, 1, 1, 1); src_b = pack4(2, 2, 2, 2);
    tick();
    checks++; if (res_data !== pack4(3, 3, 3, 3) || res_last !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_fresh_cmd: got d=%h l=%b expected d=%h l=1", res_data, res_last, pack4(3, 3, 3, 3)); end
    src_valid = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    logic [127:0] exp_add, exp_sub;
`ifdef VEXU_SATURATE_EN
    exp_add = pack4(32'h7FFF_FFFF, 32'h8000_0000, 7, 32'hFFFF_FFFF);
    exp_sub = pack4(32'h8000_0000, 32'h7FFF_FFFF, 2, 32'hFFFF_FFFE);
`else
    exp_add = pack4(32'h8000_0000, 32'h7FFF_FFFF, 7, 32'hFFFF_FFFF);
    exp_sub = pack4(32'h7FFF_FFFF, 32'h8000_0000, 2, 32'hFFFF_FFFE);
`endif
    send_cmd(3'd0, 7'd4, 1'b0, 32'd0);
    src_valid = 1'b1;
    src_a = pack4(32'h7FFF_FFFF, 32'h8000_0000, 3, 32'hFFFF_FFFE);
    src_b = pack4(1, 32'hFFFF_FFFF, 4, 1);
    tick();
    checks++; if (res_data !== exp_add) begin errors++; $display("[TB] FAIL add_overflow: got %h expected %h", res_data, exp_add); end
    src_valid = 1'b0;
    send_cmd(3'd1, 7'd4, 1'b0, 32'd0);
    src_valid = 1'b1;
    src_a = pack4(32'h8000_0000, 32'h7FFF_FFFF, 5, 32'hFFFF_FFFF);
    src_b = pack4(1, 32'hFFFF_FFFF, 3, 1);
    tick();
    checks++; if (res_data !== exp_sub) begin errors++; $display("[TB] FAIL sub_overflow: got %h expected %h", res_data, exp_sub); end
    src_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_partial();
    test_backpressure();
    test_scalar();
    test_misc_ops();
    test_vl_bounds();
    test_reset_mid();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vexecution_unit.md
Name: vexecution_unit

Overview:
- Parametrised vector integer execution unit.
- Processes a vector of VL elements as a stream of NUM_LANES-wide beats, under a command/operand/result valid-ready protocol.
- Sits between operand fetch (register file read) and writeback in the vector pipeline.
- One command is in flight at a time; one registered result stage drives writeback.

Parameters:
- NUM_LANES, 4, elements processed per beat.
- ELEM_WIDTH, 32, element width in bits (signed two's complement for MIN/MAX).
- MAX_VL, 64, maximum vector length; must be a multiple of NUM_LANES.
- VL_WIDTH, $clog2(MAX_VL)+1, width of the vector length field.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 MIN, 7 MAX.
- cmd_vl  in  VL_WIDTH  element count.
- cmd_use_scalar  in  1  replace src_b with cmd_scalar on every lane.
- cmd_scalar  in  ELEM_WIDTH  scalar operand.
- src_valid  in  1  operand beat valid.
- src_ready  out  1  operand beat accepted.
- src_a  in  NUM_LANES*ELEM_WIDTH  operand A; lane i at bits [i*ELEM_WIDTH +: ELEM_WIDTH].
- src_b  in  NUM_LANES*ELEM_WIDTH  operand B, same packing.
- res_valid  out  1  result beat valid.
- res_ready  in  1  downstream accepts result.
- res_data  out  NUM_LANES*ELEM_WIDTH  result lanes.
- res_mask  out  NUM_LANES  lane-active mask.
- res_last  out  1  final beat of the command.
- busy  out  1  state != IDLE or res_valid.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - res_valid, res_last, res_mask, res_data, busy all 0.
  - Latched command fields cleared.
  - Applies mid-command; no partial result survives.
- FSM states: IDLE, EXEC.
- IDLE:
  - cmd_ready = 1; src_ready = 0.
  - On cmd_valid: latch op, use_scalar, scalar, and eff_vl = min(cmd_vl, MAX_VL).
  - If eff_vl == 0: remain in IDLE; no result produced.
  - Otherwise: remaining = eff_vl; go to EXEC.
- EXEC:
  - cmd_ready = 0.
  - src_ready = !res_valid || res_ready (single skid-free output register).
  - On src handshake:
    - compute all lanes and load res_data/res_mask/res_last; set res_valid the next cycle (1-cycle latency).
    - remaining -= min(remaining, NUM_LANES).
  - When the beat with remaining <= NUM_LANES is accepted:
    - res_last = 1 for that beat.
    - Go to IDLE.
    - A new command may be accepted from the next cycle while the last result still waits.
- Lane mask:
  - lane i active iff i < remaining at the time of the handshake.
  - Inactive lanes: res_data lane = 0, mask bit = 0.
- Result register:
  - Holds stable while res_valid && !res_ready.
  - Simultaneous res_ready and src handshake: new beat replaces old in the same edge (full throughput, 1 beat/cycle).
  - res_valid clears when res_ready with no new src handshake.
- Arithmetic, per lane, b = use_scalar ? scalar : src_b lane:
  - ADD/SUB: modulo 2^ELEM_WIDTH.
  - AND/OR/XOR: bitwise.
  - SLL: a << b[$clog2(ELEM_WIDTH)-1:0].
  - MIN/MAX: signed compare; on equality return a.
- cmd_op, cmd_vl, cmd_use_scalar and cmd_scalar are sampled only on the cmd handshake; changes during EXEC are ignored.
- src_valid while in IDLE is not consumed (src_ready = 0).

Optional Feature:
- Macro: VEXU_SATURATE_EN.
- Defined: ADD and SUB saturate as signed. Positive overflow yields 2^(ELEM_WIDTH-1)-1; negative overflow yields -2^(ELEM_WIDTH-1). All other ops are unchanged.
- Undefined: ADD and SUB wrap modulo 2^ELEM_WIDTH.
- Ports are identical in both builds.

Test Plan:
- ADD, vl=8, src_a lanes 1..8 over two beats, src_b all 10 -> beats {11,12,13,14} mask 1111 last 0, then {15,16,17,18} mask 1111 last 1; result 1 cycle after each src handshake.
- SUB, vl=5, beat1 a=20 b=5 on all lanes, beat2 lane0 a=9 b=4 -> beat1 lanes 15 mask 1111; beat2 lane0=5, lanes1-3=0, mask 0001, last 1; FSM back to IDLE.
- res_ready held low 3 cycles on beat 1 of a vl=8 ADD -> res_data stable, src_ready 0, no beat dropped or duplicated; then back-to-back beats at 1/cycle.
- MAX, use_scalar=1, scalar=-1, a={-5,0,7,-1} -> {-1,0,7,-1}; XOR with scalar 0xFFFF_FFFF on a=0x0F0F_0F0F -> 0xF0F0_F0F0.
- Command boundaries:
  - vl=0 -> no res_valid, cmd_ready stays 1.
  - vl=100 -> clamped to 64: exactly 16 beats, last on beat 16.
  - reset asserted after beat 2 of 16 -> res_valid 0 immediately; IDLE after release.
- ADD 0x7FFF_FFFF + 1 -> 0x8000_0000 without VEXU_SATURATE_EN; 0x7FFF_FFFF with it. SUB 0x8000_0000 - 1 -> 0x7FFF_FFFF without; 0x8000_0000 with.
